// File: rtl/knight_sprite_anim_ctrl.sv
// knight_sprite_anim_ctrl: walk-cycle animation sequencer and sprite ROM
// address generator for the knight sprite.
// Optional feature macro: KNIGHT_MIRROR_EN (horizontal flip when facing left).
module knight_sprite_anim_ctrl #(
    parameter int unsigned SPR_W       = 30,
    parameter int unsigned SPR_H       = 64,
    parameter int unsigned NUM_FRAMES  = 4,
    parameter int unsigned HOLD_FRAMES = 6,
    parameter int unsigned ADDR_W      = 11,
    localparam int unsigned FS_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic              walk_req,
    input  logic              facing_left,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    output logic [ADDR_W-1:0] rom_address,
    output logic [FS_W-1:0]   frame_sel,
    output logic              sprite_hit,
    output logic              walking
);

    localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam int unsigned FULL_W = (ADDR_W > 22) ? ADDR_W : 22;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [FS_W-1:0]   FRAME_LAST = FS_W'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WALK     = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [FS_W-1:0]     frame_q, frame_d;
    logic [9:0]          lx_q, lx_d;
    logic [9:0]          ly_q, ly_d;
    logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
    logic                sprite_hit_q, sprite_hit_d;
    logic [FS_W-1:0]     frame_sel_q, frame_sel_d;
    logic                walking_q, walking_d;

`ifdef KNIGHT_MIRROR_EN
    logic                lface_q, lface_d;
`else
    logic                unused_facing;
    assign unused_facing = facing_left;
`endif

    logic [HOLD_W-1:0]   hold_inc;
    logic [FS_W-1:0]     frame_inc;
    logic                frame_wrap;

    // Animation FSM: next state, hold/frame stepping and per-frame position latch
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        frame_d    = frame_q;
        lx_d       = lx_q;
        ly_d       = ly_q;
`ifdef KNIGHT_MIRROR_EN
        lface_d    = lface_q;
`endif
        // One animation step; from IDLE (hold=0) this yields hold=1.
        hold_inc   = (hold_q == HOLD_LAST) ? '0 : hold_q + 1'b1;
        frame_wrap = (hold_q == HOLD_LAST) && (frame_q == FRAME_LAST);
        frame_inc  = frame_q;
        if (hold_q == HOLD_LAST) begin
            frame_inc = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
        end

        if (frame_tick) begin
            lx_d = sprite_x;
            ly_d = sprite_y;
`ifdef KNIGHT_MIRROR_EN
            lface_d = facing_left;
`endif
            case (state_q)
                IDLE: begin
                    if (walk_req) begin
                        state_d = WALK;
                        hold_d  = hold_inc;
                        frame_d = frame_inc;
                    end
                end
                WALK: begin
                    hold_d  = hold_inc;
                    frame_d = frame_inc;
                    if (!walk_req) begin
                        state_d = STOPPING;
                    end
                end
                STOPPING: begin
                    hold_d  = hold_inc;
                    frame_d = frame_inc;
                    if (walk_req) begin
                        state_d = WALK;
                    end else if (frame_wrap) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                    frame_d = '0;
                end
            endcase
        end
    end

    logic [10:0] x11, y11, lx11, ly11, col, row;
    logic        in_x, in_y;

    // Pixel hit test and ROM address from latched sprite position
    always_comb begin
        x11  = {1'b0, DrawX};
        y11  = {1'b0, DrawY};
        lx11 = {1'b0, lx_q};
        ly11 = {1'b0, ly_q};
        in_x = (x11 >= lx11) && (x11 < lx11 + 11'(SPR_W));
        in_y = (y11 >= ly11) && (y11 < ly11 + 11'(SPR_H));
        col  = x11 - lx11;
        row  = y11 - ly11;
`ifdef KNIGHT_MIRROR_EN
        if (lface_q) begin
            col = 11'(SPR_W - 1) - col;
        end
`endif
        sprite_hit_d  = in_x && in_y && blank;
        rom_address_d = '0;
        if (sprite_hit_d) begin
            rom_address_d = ADDR_W'(FULL_W'(row) * FULL_W'(SPR_W) + FULL_W'(col));
        end
        frame_sel_d = frame_q;
        walking_d   = (state_q != IDLE);
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            frame_q       <= '0;
            lx_q          <= '0;
            ly_q          <= '0;
            rom_address_q <= '0;
            sprite_hit_q  <= 1'b0;
            frame_sel_q   <= '0;
            walking_q     <= 1'b0;
`ifdef KNIGHT_MIRROR_EN
            lface_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            frame_q       <= frame_d;
            lx_q          <= lx_d;
            ly_q          <= ly_d;
            rom_address_q <= rom_address_d;
            sprite_hit_q  <= sprite_hit_d;
            frame_sel_q   <= frame_sel_d;
            walking_q     <= walking_d;
`ifdef KNIGHT_MIRROR_EN
            lface_q       <= lface_d;
`endif
        end
    end

    assign rom_address = rom_address_q;
    assign sprite_hit  = sprite_hit_q;
    assign frame_sel   = frame_sel_q;
    assign walking     = walking_q;

endmodule

// File: tb/tb_knight_sprite_anim_ctrl.sv
// Directed self-checking bench for knight_sprite_anim_ctrl (default parameters).
module tb_knight_sprite_anim_ctrl;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic        frame_tick;
    logic        walk_req;
    logic        facing_left;
    logic [9:0]  sprite_x, sprite_y, DrawX, DrawY;
    logic        blank;
    logic [10:0] rom_address;
    logic [1:0]  frame_sel;
    logic        sprite_hit;
    logic        walking;

    int unsigned passed = 0;
    int unsigned total  = 0;

    knight_sprite_anim_ctrl #(
        .SPR_W(30), .SPR_H(64), .NUM_FRAMES(4), .HOLD_FRAMES(6), .ADDR_W(11)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .walk_req(walk_req), .facing_left(facing_left),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .rom_address(rom_address), .frame_sel(frame_sel),
        .sprite_hit(sprite_hit), .walking(walking)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic b);
        @(negedge vga_clk);
        DrawX = x; DrawY = y; blank = b;
        @(negedge vga_clk);
    endtask

    task automatic tick();
        @(negedge vga_clk);
        frame_tick = 1'b1;
        @(negedge vga_clk);
        frame_tick = 1'b0;
        @(negedge vga_clk);
        @(negedge vga_clk);
    endtask

    task automatic chk_pix(input string tag, input int exp_addr, input logic exp_hit);
        check({tag, "_addr"}, 32'(rom_address), exp_addr);
        check({tag, "_hit"}, 32'(sprite_hit), 32'(exp_hit));
    endtask

    initial begin
        reset_n = 1'b0; frame_tick = 1'b1; walk_req = 1'b1; facing_left = 1'b0;
        sprite_x = 10'd100; sprite_y = 10'd50;
        DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;

        // Reset held with tick asserted: everything stays at zero
        repeat (3) @(negedge vga_clk);
        chk_pix("rst", 0, 1'b0);
        check("rst_frame", 32'(frame_sel), 0);
        check("rst_walk", 32'(walking), 0);
        reset_n = 1'b1; frame_tick = 1'b0; walk_req = 1'b0;
        repeat (2) @(negedge vga_clk);
        chk_pix("noTick", 0, 1'b0);
        check("noTick_walk", 32'(walking), 0);

        // Latch (100,50) and probe around the sprite box
        tick();
        chk_pix("origin", 0, 1'b1);
        check("idle_walk", 32'(walking), 0);
        pix(10'd129, 10'd113, 1'b1); chk_pix("corner", 1919, 1'b1);
        pix(10'd130, 10'd113, 1'b1); chk_pix("rightOut", 0, 1'b0);
        pix(10'd129, 10'd113, 1'b0); chk_pix("blanked", 0, 1'b0);
        pix(10'd99,  10'd50,  1'b1); chk_pix("leftOut", 0, 1'b0);
        pix(10'd100, 10'd114, 1'b1); chk_pix("bottomOut", 0, 1'b0);
        pix(10'd105, 10'd52,  1'b1); chk_pix("inner", 65, 1'b1);

        // Position change takes effect only at the next tick
        sprite_x = 10'd200;
        pix(10'd129, 10'd113, 1'b1); chk_pix("noRelatch", 1919, 1'b1);
        tick();
        chk_pix("relatched", 0, 1'b0);
        pix(10'd200, 10'd50, 1'b1); chk_pix("newOrigin", 0, 1'b1);
        pix(10'd229, 10'd50, 1'b1); chk_pix("newRight", 29, 1'b1);

        // Facing-left latch
        sprite_x = 10'd0; sprite_y = 10'd0; facing_left = 1'b1;
        tick();
`ifdef KNIGHT_MIRROR_EN
        pix(10'd0, 10'd1, 1'b1);  chk_pix("mirrorRow1", 59, 1'b1);
        pix(10'd29, 10'd0, 1'b1); chk_pix("mirrorEdge", 0, 1'b1);
`else
        pix(10'd0, 10'd1, 1'b1);  chk_pix("mirrorRow1", 30, 1'b1);
        pix(10'd29, 10'd0, 1'b1); chk_pix("mirrorEdge", 29, 1'b1);
`endif
        facing_left = 1'b0;
        tick();

        // Walk from IDLE through one full cycle and on to frame 2
        walk_req = 1'b1;
        for (int t = 1; t <= 36; t++) begin
            tick();
            check($sformatf("walk_t%0d_frame", t), 32'(frame_sel), (t / 6) % 4);
            check($sformatf("walk_t%0d_walk", t), 32'(walking), 1);
        end

        // Drop request at frame 2: finish 2, 3, wrap to 0 and go idle
        walk_req = 1'b0;
        for (int t = 37; t <= 49; t++) begin
            tick();
            check($sformatf("stop_t%0d_frame", t), 32'(frame_sel), (t / 6) % 4);
            check($sformatf("stop_t%0d_walk", t), 32'(walking), (t < 48) ? 1 : 0);
        end

        // Re-raise during STOPPING at frame 3: frame continues without reset
        for (int t = 1; t <= 24; t++) begin
            if (t == 1)  walk_req = 1'b1;
            if (t == 13) walk_req = 1'b0;
            if (t == 19) walk_req = 1'b1;
            tick();
            check($sformatf("rearm_t%0d_frame", t), 32'(frame_sel), (t / 6) % 4);
            check($sformatf("rearm_t%0d_walk", t), 32'(walking), 1);
        end

        // Move to (100,50) and walk into frame 1, then reset mid-cycle
        sprite_x = 10'd100; sprite_y = 10'd50;
        for (int t = 25; t <= 30; t++) tick();
        check("preRst_frame", 32'(frame_sel), 1);
        pix(10'd105, 10'd52, 1'b1); chk_pix("preRst", 65, 1'b1);

        @(posedge vga_clk);
        #2 reset_n = 1'b0; frame_tick = 1'b1;
        #1;
        chk_pix("asyncRst", 0, 1'b0);
        check("asyncRst_frame", 32'(frame_sel), 0);
        check("asyncRst_walk", 32'(walking), 0);
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1; frame_tick = 1'b0;
        repeat (2) @(negedge vga_clk);
        chk_pix("postRst", 0, 1'b0);
        check("postRst_frame", 32'(frame_sel), 0);
        check("postRst_walk", 32'(walking), 0);

        // First tick after reset starts from IDLE with hold=1
        for (int t = 1; t <= 6; t++) begin
            tick();
            check($sformatf("restart_t%0d_frame", t), 32'(frame_sel), (t == 6) ? 1 : 0);
            check($sformatf("restart_t%0d_walk", t), 32'(walking), 1);
        end
        chk_pix("restartPix", 65, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
